// File: rtl/lab7soc_switch_poller.sv
// Avalon-MM read master that polls the switch PIO data register at a fixed
// period and debounces the sampled value before presenting it to fabric logic.
module lab7soc_switch_poller #(
  parameter int unsigned POLL_CYCLES = 1000,
  parameter int unsigned DEB_COUNT   = 4,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear_err,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] sw_stable,
  output logic              sw_changed,
  output logic              err_timeout
);

  localparam int unsigned POLL_W = $clog2(POLL_CYCLES) + 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT) + 1;
  localparam int unsigned DEB_W  = $clog2(DEB_COUNT) + 1;

  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [DEB_W-1:0]  DEB_FULL  = DEB_W'(DEB_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
  logic [DATA_W-1:0]   cand_q, cand_d;
  logic [DATA_W-1:0]   stable_q, stable_d;
  logic                changed_q, changed_d;
  logic                err_q, err_d;

  logic                poll_tick;
  logic                samp_valid;
  logic                timeout_hit;
  logic [DATA_W-1:0]   samp;

  assign samp = avm_readdata[DATA_W-1:0];

  generate
    if (DATA_W < 32) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^avm_readdata[31:DATA_W];
    end
  endgenerate

  // Free-running period counter; it keeps counting through REQ/WAIT so the
  // poll period stays exact, and is held at zero while polling is disabled.
  always_comb begin
    poll_tick  = enable && (poll_cnt_q == POLL_LAST);
    poll_cnt_d = poll_cnt_q + POLL_W'(1);
    if (!enable || poll_tick) begin
      poll_cnt_d = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    samp_valid  = 1'b0;
    timeout_hit = 1'b0;
    avm_read    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (poll_tick) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          state_d  = ST_WAIT;
          to_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (avm_readdatavalid) begin
          samp_valid = 1'b1;
          state_d    = ST_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The stable value is committed from the post-update candidate/count so the
  // change pulse lands in the cycle right after the qualifying capture.
  always_comb begin
    cand_d    = cand_q;
    deb_cnt_d = deb_cnt_q;
    stable_d  = stable_q;
    changed_d = 1'b0;
    if (samp_valid) begin
      if (samp != cand_q) begin
        cand_d    = samp;
        deb_cnt_d = DEB_W'(1);
      end else if (deb_cnt_q < DEB_FULL) begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
      if ((deb_cnt_d == DEB_FULL) && (cand_d != stable_q)) begin
        stable_d  = cand_d;
        changed_d = 1'b1;
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (clear_err) begin
      err_d = 1'b0;
    end
    if (timeout_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      poll_cnt_q <= '0;
      to_cnt_q   <= '0;
      deb_cnt_q  <= '0;
      cand_q     <= '0;
      stable_q   <= '0;
      changed_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      to_cnt_q   <= to_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      changed_q  <= changed_d;
      err_q      <= err_d;
    end
  end

  assign avm_address = '0;
  assign sw_stable   = stable_q;
  assign sw_changed  = changed_q;
  assign err_timeout = err_q;

endmodule
